mac_booth_r4_seq: RTL and testbench

- Parametrised, iterative radix-4 Booth multiply-accumulate unit; successor to the fixed 24-bit unsigned Booth MAC.
- Adds the following over the fixed unit:
  - configurable operand width;
  - per-transaction signed/unsigned mode;
  - optional accumulation into a wide internal accumulator;
  - valid/ready handshakes on input and output.
- Sits in the FP32 mantissa datapath and in the integer TPU PE lanes.

---
 rtl/mac_booth_pkg.sv | 21 ++
 rtl/booth_r4_digit_pp.sv | 35 +++
 rtl/mac_booth_r4_seq.sv | 150 +++++++++++++++
 tb/tb_mac_booth_r4_seq.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_booth_pkg.sv
// Shared types and the radix-4 Booth recoding function for the mac_booth_r4_seq unit.
package mac_booth_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} digit_t;

    // Triplet is {b[2i+1], b[2i], b[2i-1]}; weights are -2*b[2i+1] + b[2i] + b[2i-1].
    function automatic digit_t booth_digit(input logic [2:0] triplet);
        digit_t d;
        case (triplet)
            3'b001, 3'b010: d = POS1;
            3'b011:         d = POS2;
            3'b100:         d = NEG2;
            3'b101, 3'b110: d = NEG1;
            default:        d = ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_r4_digit_pp.sv
// Combinational radix-4 Booth term: digit(triplet) * a_ext, shifted left by shift_i bits.
module booth_r4_digit_pp
    import mac_booth_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int PW    = 2 * WIDTH + 4,
    parameter int SHW   = $clog2(PW)
) (
    input  logic [2:0]       triplet_i,
    input  logic [WIDTH+1:0] a_ext_i,
    input  logic [SHW-1:0]   shift_i,
    output logic [PW-1:0]    pp_o
);

    digit_t          digit;
    logic [PW-1:0]   a_wide;
    logic [PW-1:0]   mag;

    // NOTE: every variable gets a value on every path through always_comb so no latch is inferred.
    always_comb begin
        digit  = booth_digit(triplet_i);
        a_wide = PW'($signed(a_ext_i));
        mag    = '0;
        case (digit)
            POS1:    mag = a_wide;
            POS2:    mag = a_wide << 1;
            NEG1:    mag = -a_wide;
            NEG2:    mag = -(a_wide << 1);
            default: mag = '0;
        endcase
    end

    assign pp_o = mag << shift_i;

endmodule

// File: rtl/mac_booth_r4_seq.sv
// Iterative radix-4 Booth multiply-accumulate with valid/ready handshakes.
// Define MAC_BOOTH_SATURATE_EN to saturate the accumulator and drive a sticky ovf flag.
module mac_booth_r4_seq
    import mac_booth_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int ACC_W = 56
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    input  logic             acc_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result,
    output logic             ovf
);

    localparam int ITER = (WIDTH + 2) / 2;
    localparam int PW   = 2 * WIDTH + 4;
    localparam int CW   = $clog2(ITER + 1);
    localparam int SHW  = $clog2(PW);

    state_t           state_q;
    logic [WIDTH+1:0] a_ext_q;
    logic [WIDTH+2:0] b_sh_q;
    logic             signed_q;
    logic             acc_en_q;
    logic [PW-1:0]    pp_q;
    logic [CW-1:0]    cnt_q;
    logic [ACC_W-1:0] acc_q;
    logic             ovf_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [SHW-1:0]   shift;
    logic [PW-1:0]    pp_term;
    logic [PW-1:0]    pp_d;
    logic [ACC_W-1:0] acc_base;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] acc_d;
    logic             sat_hit;

    // b_sh_q keeps b_ext with a zero appended below bit 0, so [2:0] is always the current triplet.
    assign shift = SHW'({cnt_q, 1'b0});

    booth_r4_digit_pp #(
        .WIDTH (WIDTH),
        .PW    (PW),
        .SHW   (SHW)
    ) u_digit_pp (
        .triplet_i (b_sh_q[2:0]),
        .a_ext_i   (a_ext_q),
        .shift_i   (shift),
        .pp_o      (pp_term)
    );

    assign pp_d = pp_q + pp_term;

    always_comb begin
        acc_base = acc_en_q ? acc_q : '0;
        if (signed_q) prod_ext = ACC_W'($signed(pp_d[2*WIDTH-1:0]));
        else          prod_ext = ACC_W'(pp_d[2*WIDTH-1:0]);
    end

`ifdef MAC_BOOTH_SATURATE_EN
    logic [ACC_W:0] sum;

    always_comb begin
        sum     = {1'b0, acc_base} + {1'b0, prod_ext};
        acc_d   = sum[ACC_W-1:0];
        sat_hit = 1'b0;
        if (signed_q) begin
            if ((acc_base[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_base[ACC_W-1])) begin
                sat_hit = 1'b1;
                acc_d   = acc_base[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
            end
        end else if (sum[ACC_W]) begin
            sat_hit = 1'b1;
            acc_d   = '1;
        end
    end
`else
    always_comb begin
        acc_d   = acc_base + prod_ext;
        sat_hit = 1'b0;
    end
`endif

    // NOTE: all state here updates with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_ext_q     <= '0;
            b_sh_q      <= '0;
            signed_q    <= 1'b0;
            acc_en_q    <= 1'b0;
            pp_q        <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_ext_q    <= is_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
                        b_sh_q     <= is_signed ? {{2{b[WIDTH-1]}}, b, 1'b0} : {2'b00, b, 1'b0};
                        signed_q   <= is_signed;
                        acc_en_q   <= acc_en;
                        pp_q       <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    pp_q   <= pp_d;
                    b_sh_q <= {{2{b_sh_q[WIDTH+2]}}, b_sh_q[WIDTH+2:2]};
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == CW'(ITER - 1)) begin
                        acc_q       <= acc_d;
                        ovf_q       <= (acc_en_q & ovf_q) | sat_hit;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = acc_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_mac_booth_r4_seq.sv
// Self-checking bench for mac_booth_r4_seq: directed spec cases plus randomized beats
// compared against a plain-arithmetic accumulate model.
module tb_mac_booth_r4_seq;

    localparam int WIDTH = 24;
    localparam int ACC_W = 48;
    localparam int ITER  = (WIDTH + 2) / 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             is_signed = 1'b0;
    logic             acc_en = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [ACC_W-1:0] result;
    logic             ovf;

    int checks = 0;
    int errors = 0;

    logic [ACC_W-1:0] m_acc = '0;
    logic             m_ovf = 1'b0;

    mac_booth_r4_seq #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .acc_en    (acc_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Reference model: true integer product, then accumulate with wrap or clamp.
    task automatic model_beat(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                              input logic ms, input logic men);
        longint pa, pb, prod, sum, base;
        logic [63:0] bits;
        if (ms) begin
            pa = longint'($signed(ma));
            pb = longint'($signed(mb));
        end else begin
            pa = longint'({40'd0, ma});
            pb = longint'({40'd0, mb});
        end
        prod = pa * pb;
        if (!men) begin
            m_acc = '0;
            m_ovf = 1'b0;
        end
`ifdef MAC_BOOTH_SATURATE_EN
        if (ms) begin
            base = longint'($signed(m_acc));
            sum  = base + prod;
            if (sum > (64'sd1 <<< (ACC_W - 1)) - 1) begin
                sum = (64'sd1 <<< (ACC_W - 1)) - 1;
                m_ovf = 1'b1;
            end else if (sum < -(64'sd1 <<< (ACC_W - 1))) begin
                sum = -(64'sd1 <<< (ACC_W - 1));
                m_ovf = 1'b1;
            end
        end else begin
            base = longint'({16'd0, m_acc});
            sum  = base + prod;
            if (sum > (64'sd1 <<< ACC_W) - 1) begin
                sum = (64'sd1 <<< ACC_W) - 1;
                m_ovf = 1'b1;
            end
        end
`else
        base = longint'({16'd0, m_acc});
        sum  = base + prod;
`endif
        bits  = sum;
        m_acc = bits[ACC_W-1:0];
    endtask

    task automatic send_beat(input logic [WIDTH-1:0] sa, input logic [WIDTH-1:0] sb,
                             input logic ss, input logic se);
        int n = 0;
        while (!in_ready && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL in_ready_timeout: in_ready=%0b required=1", in_ready);
        end
        a = sa; b = sb; is_signed = ss; acc_en = se; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // lat counts the accept edge as 1, then each further edge until out_valid is seen.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < ITER + 30) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) begin
            checks++; errors++;
            $display("FAIL out_valid_timeout: out_valid=%0b required=1", out_valid);
        end
    endtask

    task automatic pop(output logic [ACC_W-1:0] res, output logic ov);
        res = result;
        ov  = ovf;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic do_beat(input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db,
                           input logic ds, input logic de,
                           output logic [ACC_W-1:0] res, output logic ov, output int lat);
        send_beat(da, db, ds, de);
        model_beat(da, db, ds, de);
        wait_out(lat);
        pop(res, ov);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%0b out_valid=%0b result=%h ovf=%0b required 1 0 0 0",
                     in_ready, out_valid, result, ovf);
        end
        m_acc = '0;
        m_ovf = 1'b0;
    endtask

    task automatic test_unsigned();
        logic [WIDTH-1:0] ta [3] = '{24'hFFFFFF, 24'h800000, 24'h000000};
        logic [WIDTH-1:0] tb [3] = '{24'hFFFFFF, 24'h000002, 24'h000000};
        logic [ACC_W-1:0] exp [3] = '{48'hFFFFFE000001, 48'h000001000000, 48'h0};
        logic [ACC_W-1:0] res;
        logic ov;
        int lat;
        for (int i = 0; i < 3; i++) begin
            do_beat(ta[i], tb[i], 1'b0, 1'b0, res, ov, lat);
            checks++;
            if (res !== exp[i] || res !== m_acc) begin
                errors++;
                $display("FAIL unsigned_%0d: result=%h required=%h", i, res, exp[i]);
            end
            checks++;
            if (lat != ITER + 1) begin
                errors++;
                $display("FAIL latency_%0d: got=%0d required=%0d", i, lat, ITER + 1);
            end
        end
    endtask

    task automatic test_signed();
        logic [ACC_W-1:0] res;
        logic ov;
        int lat;
        do_beat(24'hFFFFFF, 24'h000003, 1'b1, 1'b0, res, ov, lat);
        checks++;
        if (res !== 48'hFFFFFFFFFFFD) begin
            errors++;
            $display("FAIL signed_neg1x3: result=%h required=%h", res, 48'hFFFFFFFFFFFD);
        end
        do_beat(24'h800000, 24'h800000, 1'b1, 1'b0, res, ov, lat);
        checks++;
        if (res !== 48'h400000000000 || res !== m_acc) begin
            errors++;
            $display("FAIL signed_min_sq: result=%h required=%h", res, 48'h400000000000);
        end
    endtask

    task automatic test_accumulate();
        logic [ACC_W-1:0] res;
        logic ov;
        int lat;
        do_beat(24'd5, 24'd7, 1'b0, 1'b0, res, ov, lat);
        checks++;
        if (res !== 48'd35) begin
            errors++; $display("FAIL acc_beat1: result=%0d required=35", res);
        end
        do_beat(24'd3, 24'd4, 1'b0, 1'b1, res, ov, lat);
        checks++;
        if (res !== 48'd47) begin
            errors++; $display("FAIL acc_beat2: result=%0d required=47", res);
        end
        do_beat(24'hFFFFFE, 24'd6, 1'b1, 1'b1, res, ov, lat);
        checks++;
        if (res !== 48'd35 || res !== m_acc) begin
            errors++; $display("FAIL acc_beat3: result=%0d required=35", res);
        end
    endtask

    task automatic test_backpressure();
        logic [ACC_W-1:0] res;
        logic ov;
        int lat;
        int bad = 0;
        send_beat(24'h123456, 24'h000654, 1'b0, 1'b0);
        model_beat(24'h123456, 24'h000654, 1'b0, 1'b0);
        wait_out(lat);
        for (int i = 0; i < 20; i++) begin
            a = 24'($urandom); b = 24'($urandom); acc_en = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1;
            if (result !== m_acc || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
        end
        in_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL backpressure_hold: bad_cycles=%0d required=0 (result=%h expected=%h)", bad, result, m_acc);
        end
        pop(res, ov);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: in_ready=%0b out_valid=%0b required 1 0", in_ready, out_valid);
        end
        // An ignored beat would have reloaded the accumulator; acc_en=1 here exposes that.
        do_beat(24'd1, 24'd1, 1'b0, 1'b1, res, ov, lat);
        checks++;
        if (res !== m_acc) begin
            errors++;
            $display("FAIL backpressure_ignored: result=%h required=%h", res, m_acc);
        end
    endtask

    task automatic test_reset_mid_calc();
        logic [ACC_W-1:0] res;
        logic ov;
        int lat;
        int seen = 0;
        send_beat(24'd9, 24'd9, 1'b0, 1'b1);
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_acc = '0;
        m_ovf = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_calc_state: in_ready=%0b out_valid=%0b result=%h ovf=%0b required 1 0 0 0",
                     in_ready, out_valid, result, ovf);
        end
        repeat (ITER + 4) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_mid_calc_no_valid: valid_cycles=%0d required=0", seen);
        end
        do_beat(24'd2, 24'd3, 1'b0, 1'b1, res, ov, lat);
        checks++;
        if (res !== 48'd6) begin
            errors++;
            $display("FAIL reset_mid_calc_next: result=%0d required=6", res);
        end
    endtask

    task automatic test_saturate();
        logic [ACC_W-1:0] res;
        logic ov;
        logic [ACC_W-1:0] exp_res;
        logic exp_ov;
        int lat;
`ifdef MAC_BOOTH_SATURATE_EN
        exp_res = 48'hFFFFFFFFFFFF;
        exp_ov  = 1'b1;
`else
        exp_res = 48'hFFFFFC000002;
        exp_ov  = 1'b0;
`endif
        do_beat(24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b0, res, ov, lat);
        do_beat(24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b1, res, ov, lat);
        checks++;
        if (res !== exp_res || ov !== exp_ov || res !== m_acc || ov !== m_ovf) begin
            errors++;
            $display("FAIL overflow: result=%h ovf=%0b required=%h ovf=%0b", res, ov, exp_res, exp_ov);
        end
        do_beat(24'd1, 24'd1, 1'b0, 1'b0, res, ov, lat);
        checks++;
        if (res !== 48'd1 || ov !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear: result=%h ovf=%0b required=1 ovf=0", res, ov);
        end
    endtask

    function automatic logic [WIDTH-1:0] pick_op();
        case ($urandom_range(0, 4))
            0:       return '1;
            1:       return {1'b1, {(WIDTH-1){1'b0}}};
            2:       return {1'b0, {(WIDTH-1){1'b1}}};
            default: return WIDTH'($urandom);
        endcase
    endfunction

    task automatic test_random();
        logic [ACC_W-1:0] res;
        logic ov;
        int lat;
        int bad = 0;
        logic [WIDTH-1:0] ra, rb;
        logic rs, re;
        for (int i = 0; i < 40; i++) begin
            ra = pick_op();
            rb = pick_op();
            rs = 1'($urandom);
            re = ($urandom_range(0, 3) != 0);
            send_beat(ra, rb, rs, re);
            model_beat(ra, rb, rs, re);
            wait_out(lat);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            pop(res, ov);
            checks++;
            if (res !== m_acc || ov !== m_ovf || lat != ITER + 1) begin
                errors++;
                bad++;
                $display("FAIL random_%0d: a=%h b=%h s=%0b en=%0b result=%h ovf=%0b lat=%0d required=%h ovf=%0b lat=%0d",
                         i, ra, rb, rs, re, res, ov, lat, m_acc, m_ovf, ITER + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_accumulate();
        test_backpressure();
        test_reset_mid_calc();
        test_saturate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
